// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with a registered one-hot grant
// held under backpressure and released through a valid/ready handshake.
module rr_arbiter_16 (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] grant
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d, g_idx, nxt;
   logic [15:0] grant_q, grant_d;
   // Rotate so the base sits at bit 0, isolate the lowest set bit, rotate back.
   function automatic logic [15:0] pick(input logic [15:0] r, input logic [3:0] p);
      logic [31:0] d;
      logic [15:0] rot, oh;
      d   = {r, r} >> p;
      rot = d[15:0];
      oh  = rot & (~rot + 16'd1);
      d   = {oh, oh} << p;
      return d[31:16];
   endfunction
   always_comb begin
      g_idx = 4'd0;
      for (int i = 0; i < 16; i++) g_idx = g_idx | (grant_q[i] ? 4'(i) : 4'd0);
      nxt     = g_idx + 4'd1;
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      if (flush) begin
         state_d = IDLE;
         grant_d = '0;
      end else if (state_q == IDLE) begin
         state_d = |req ? GRANT : IDLE;
         grant_d = pick(req, ptr_q);
      end else if (out_ready) begin
         ptr_d   = nxt;
         state_d = |req ? GRANT : IDLE;
         grant_d = pick(req, nxt);
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end
   assign out_valid = state_q == GRANT;
   assign grant     = grant_q;
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: directed vectors feed a scoreboard queue; a negedge
// monitor pops one expected grant per cycle and compares it.
module tb_rr_arbiter_16;
   logic        clock = 0, reset = 1, flush = 0, out_ready = 0, out_valid;
   logic [15:0] req = '0, grant;
   logic [15:0] exp_q[$];
   int          n_vec = 0, n_bad = 0;

   rr_arbiter_16 dut (
      .clock(clock), .reset(reset), .req(req), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .grant(grant)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [16:0] act, input logic [16:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   // Drive one cycle and record what the grant must look like after the edge.
   task automatic step(input logic [15:0] r, input logic rdy, input logic fl, input logic [15:0] e);
      req = r;
      out_ready = rdy;
      flush = fl;
      @(posedge clock);
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         e = exp_q.pop_front();
         chk("grant", {out_valid, grant}, {|e, e});
         chk("onehot0", 17'($onehot0(grant)), 17'd1);
      end else if (out_valid) begin
         chk("unexpected_valid", {out_valid, grant}, 17'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #12;
      chk("reset_state", {out_valid, grant}, 17'd0);
      reset = 0;
      // single requester, repeated grants
      for (int i = 0; i < 4; i++) step(16'h0010, 1, 0, 16'h0010);
      // grant 15 then drain so ptr wraps to 0
      step(16'h8000, 1, 0, 16'h8000);
      step(16'h0000, 1, 0, 16'h0000);
      // full rotation with wrap
      for (int k = 0; k < 17; k++) step(16'hFFFF, 1, 0, 16'h0001 << (k % 16));
      // backpressure hold
      step(16'h0006, 1, 0, 16'h0002);
      step(16'h0006, 0, 0, 16'h0002);
      for (int i = 0; i < 4; i++) step(16'h0004, 0, 0, 16'h0002);
      step(16'h0004, 1, 0, 16'h0004);
      // ptr = 14, skip past pointer with wrap
      step(16'h2000, 1, 0, 16'h2000);
      step(16'h0101, 1, 0, 16'h0001);
      step(16'h0101, 1, 0, 16'h0100);
      // flush colliding with ready leaves ptr at 3
      step(16'h0004, 1, 0, 16'h0004);
      step(16'h0008, 1, 0, 16'h0008);
      step(16'h0008, 0, 0, 16'h0008);
      step(16'h0008, 1, 1, 16'h0000);
      step(16'h0000, 1, 0, 16'h0000);
      step(16'hFFFF, 0, 0, 16'h0008);
      // async reset mid-grant
      step(16'h0400, 1, 0, 16'h0400);
      step(16'h0400, 0, 0, 16'h0400);
      @(negedge clock);
      #1 reset = 1;
      #1 chk("async_reset", {out_valid, grant}, 17'd0);
      #1 reset = 0;
      step(16'hFFFF, 1, 0, 16'h0001);
      step(16'hFFFF, 1, 0, 16'h0002);
      step(16'h0000, 1, 0, 16'h0000);
      step(16'h0000, 0, 0, 16'h0000);
      @(negedge clock);
      #1;
      if (exp_q.size() != 0) chk("queue_drained", 17'(exp_q.size()), 17'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
